unidade_controle_param: RTL and testbench

//  Parametrised control FSM for the multicycle bus processor. It owns its own step

---
 rtl/unidade_controle_param_pkg.sv | 36 +++
 rtl/unidade_controle_param_if.sv | 43 ++++
 rtl/unidade_controle_param_decode_onehot.sv | 16 +
 rtl/unidade_controle_param.sv | 161 ++++++++++++++++
 tb/tb_unidade_controle_param.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_param_pkg.sv
// Shared encodings for the multicycle bus processor control unit:
// FSM states, instruction opcodes and ALU operation codes.
package unidade_controle_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FWAIT = 3'd2,
    S_T1    = 3'd3,
    S_T2    = 3'd4,
    S_T3    = 3'd5
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_AND = 2'b10;

  // Maps a three-operand ALU opcode to the code the ALU expects
  function automatic logic [1:0] ulaCode(input logic [2:0] op);
    case (op)
      OP_SUB:  return ULA_SUB;
      OP_AND:  return ULA_AND;
      default: return ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_param_if.sv
// Bundle of control-unit inputs (run, IR, G, memory ready) and the
// enables it drives onto the shared-bus datapath. The control unit is
// the master; the datapath (or a testbench) is the slave.
interface unidade_controle_param_if #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int OPCODE_W = 3
);
  localparam int RSEL_W  = $clog2(NREG);
  localparam int INSTR_W = OPCODE_W + 2 * RSEL_W;

  logic               Run;
  logic [INSTR_W-1:0] Instrucao;
  logic [DATA_W-1:0]  GRout;
  logic               MemRdy;

  logic               IncrPc;
  logic               IRin;
  logic               ADDRin;
  logic               DOUTin;
  logic               W_D;
  logic [NREG-1:0]    Rin;
  logic [NREG-1:0]    Rout;
  logic               Ain;
  logic               Gin;
  logic               Gout;
  logic [1:0]         Ulaop;
  logic               DINout;
  logic               Done;
  logic               Busy;

  modport master (
    input  Run, Instrucao, GRout, MemRdy,
    output IncrPc, IRin, ADDRin, DOUTin, W_D, Rin, Rout,
           Ain, Gin, Gout, Ulaop, DINout, Done, Busy
  );

  modport slave (
    output Run, Instrucao, GRout, MemRdy,
    input  IncrPc, IRin, ADDRin, DOUTin, W_D, Rin, Rout,
           Ain, Gin, Gout, Ulaop, DINout, Done, Busy
  );
endinterface

// File: rtl/unidade_controle_param_decode_onehot.sv
// Register-select decoder: turns a register index into a one-hot
// enable vector, all zeros when not enabled.
module decode_onehot #(
  parameter int NREG = 8,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic [RSEL_W-1:0] W,
  input  logic              En,
  output logic [NREG-1:0]   Y
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  assign Y = En ? (ONE << W) : '0;

endmodule

// File: rtl/unidade_controle_param.sv
// Control FSM for the multicycle shared-bus processor. Fetches each
// instruction through the PC register with a MemRdy handshake, then
// sequences the register/ALU/memory enables for up to three steps.
module unidade_controle_param
  import unidade_controle_param_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NREG       = 8,
  parameter int OPCODE_W   = 3,
  parameter int PC_IDX     = NREG - 1,
  parameter int CONTINUOUS = 1
) (
  input logic Clock,
  input logic Resetn,
  unidade_controle_param_if.master bus
);

  localparam int RSEL_W  = $clog2(NREG);
  localparam int INSTR_W = OPCODE_W + 2 * RSEL_W;
  localparam logic [NREG-1:0] PC_ONEHOT = {{(NREG-1){1'b0}}, 1'b1} << PC_IDX;

  state_t state_q, state_d;
  logic   runPrev_q;

  logic [OPCODE_W-1:0] opField;
  logic [2:0]          opcode;
  logic [RSEL_W-1:0]   rxSel, rySel;
  logic [NREG-1:0]     rxOneHot, ryOneHot;
  logic [DATA_W-1:0]   gValue;
  logic                gNonZero, rxIsPc, isAlu, afterDone;

  logic            incrPc, irIn, addrIn, doutIn, wD, aIn, gIn, gOut, dinOut, done;
  logic [NREG-1:0] rIn, rOut;
  logic [1:0]      ulaOp;

  assign opField  = bus.Instrucao[INSTR_W-1 -: OPCODE_W];
  assign opcode   = 3'(opField);
  assign rxSel    = bus.Instrucao[2*RSEL_W-1 -: RSEL_W];
  assign rySel    = bus.Instrucao[RSEL_W-1:0];
  assign gValue   = bus.GRout;
  assign gNonZero = |gValue;
  assign rxIsPc   = (rxSel == RSEL_W'(PC_IDX));
  assign isAlu    = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

  // After the final step, keep fetching only in continuous mode with Run held
  assign afterDone = ((CONTINUOUS != 0) && bus.Run) ? 1'b1 : 1'b0;

  decode_onehot #(.NREG(NREG)) u_decRx (.W(rxSel), .En(1'b1), .Y(rxOneHot));
  decode_onehot #(.NREG(NREG)) u_decRy (.W(rySel), .En(1'b1), .Y(ryOneHot));

  // State and Run history registers; reset dominates any Run activity
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q   <= S_IDLE;
      runPrev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      runPrev_q <= bus.Run;
    end
  end

  // Step sequencing: memory steps stall on MemRdy, last steps loop or idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.Run && !runPrev_q) state_d = S_FETCH;
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: if (bus.MemRdy) state_d = S_T1;
      S_T1: begin
        if (opcode == OP_MV || opcode == OP_MVNZ)
          state_d = afterDone ? S_FETCH : S_IDLE;
        else
          state_d = S_T2;
      end
      S_T2: begin
        if (opcode == OP_MVI || opcode == OP_LD) begin
          if (bus.MemRdy) state_d = afterDone ? S_FETCH : S_IDLE;
        end else if (isAlu || opcode == OP_ST) begin
          state_d = S_T3;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T3: begin
        if (isAlu) state_d = afterDone ? S_FETCH : S_IDLE;
        else if (opcode == OP_ST) begin
          if (bus.MemRdy) state_d = afterDone ? S_FETCH : S_IDLE;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath enables for the current step; wait steps keep everything low
  always_comb begin
    incrPc = 1'b0; irIn = 1'b0; addrIn = 1'b0; doutIn = 1'b0; wD = 1'b0;
    aIn = 1'b0; gIn = 1'b0; gOut = 1'b0; dinOut = 1'b0; done = 1'b0;
    rIn = '0; rOut = '0; ulaOp = ULA_ADD;
    case (state_q)
      S_FETCH: begin
        rOut = PC_ONEHOT; addrIn = 1'b1;
      end
      S_FWAIT: begin
        if (bus.MemRdy) begin irIn = 1'b1; incrPc = 1'b1; end
      end
      S_T1: begin
        case (opcode)
          OP_MV:  begin rOut = ryOneHot; rIn = rxOneHot; done = 1'b1; end
          OP_MVI: begin rOut = PC_ONEHOT; addrIn = 1'b1; end
          OP_LD, OP_ST: begin rOut = ryOneHot; addrIn = 1'b1; end
          OP_MVNZ: begin
            if (gNonZero) begin rOut = ryOneHot; rIn = rxOneHot; end
            done = 1'b1;
          end
          default: begin rOut = rxOneHot; aIn = 1'b1; end
        endcase
      end
      S_T2: begin
        case (opcode)
          OP_MVI: begin
            if (bus.MemRdy) begin
              dinOut = 1'b1; rIn = rxOneHot; incrPc = !rxIsPc; done = 1'b1;
            end
          end
          OP_LD: begin
            if (bus.MemRdy) begin dinOut = 1'b1; rIn = rxOneHot; done = 1'b1; end
          end
          OP_ST: begin rOut = rxOneHot; doutIn = 1'b1; end
          OP_ADD, OP_SUB, OP_AND: begin
            rOut = ryOneHot; gIn = 1'b1; ulaOp = ulaCode(opcode);
          end
          default: ;
        endcase
      end
      S_T3: begin
        if (opcode == OP_ST) begin
          wD = 1'b1; done = bus.MemRdy;
        end else if (isAlu) begin
          gOut = 1'b1; rIn = rxOneHot; done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.IncrPc = incrPc;
  assign bus.IRin   = irIn;
  assign bus.ADDRin = addrIn;
  assign bus.DOUTin = doutIn;
  assign bus.W_D    = wD;
  assign bus.Rin    = rIn;
  assign bus.Rout   = rOut;
  assign bus.Ain    = aIn;
  assign bus.Gin    = gIn;
  assign bus.Gout   = gOut;
  assign bus.Ulaop  = ulaOp;
  assign bus.DINout = dinOut;
  assign bus.Done   = done;
  assign bus.Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed bench for the control unit: each task walks one instruction
// cycle by cycle against a hand-written table of expected enables.
module tb_unidade_controle_param;
  import unidade_controle_param_pkg::*;

  logic Clock;
  logic Resetn;
  int   compared   = 0;
  int   mismatched = 0;

  unidade_controle_param_if #(.DATA_W(16), .NREG(8), .OPCODE_W(3)) bus ();

  unidade_controle_param #(
    .DATA_W(16), .NREG(8), .OPCODE_W(3), .PC_IDX(7), .CONTINUOUS(1)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed view of every output: {IncrPc,IRin,ADDRin,DOUTin,W_D,Rin,Rout,Ain,Gin,Gout,Ulaop,DINout,Done,Busy}
  localparam logic [28:0] O_INCR   = 29'd1 << 28;
  localparam logic [28:0] O_IRIN   = 29'd1 << 27;
  localparam logic [28:0] O_ADDRIN = 29'd1 << 26;
  localparam logic [28:0] O_DOUTIN = 29'd1 << 25;
  localparam logic [28:0] O_WD     = 29'd1 << 24;
  localparam logic [28:0] O_AIN    = 29'd1 << 7;
  localparam logic [28:0] O_GIN    = 29'd1 << 6;
  localparam logic [28:0] O_GOUT   = 29'd1 << 5;
  localparam logic [28:0] O_DINOUT = 29'd1 << 2;
  localparam logic [28:0] O_DONE   = 29'd1 << 1;
  localparam logic [28:0] O_BUSY   = 29'd1;
  localparam logic [28:0] E_FETCH  = (29'h80 << 8) | O_ADDRIN | O_BUSY;
  localparam logic [28:0] E_FWRDY  = O_IRIN | O_INCR | O_BUSY;

  function automatic logic [28:0] fRout(input logic [7:0] x);
    return {13'd0, x, 8'd0};
  endfunction

  function automatic logic [28:0] fRin(input logic [7:0] x);
    return {5'd0, x, 16'd0};
  endfunction

  function automatic logic [28:0] fUla(input logic [1:0] u);
    return {24'd0, u, 3'd0};
  endfunction

  function automatic logic [28:0] outVec();
    return {bus.IncrPc, bus.IRin, bus.ADDRin, bus.DOUTin, bus.W_D, bus.Rin, bus.Rout,
            bus.Ain, bus.Gin, bus.Gout, bus.Ulaop, bus.DINout, bus.Done, bus.Busy};
  endfunction

  task automatic test_reset();
    Resetn = 1'b1;
    bus.Run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      compared++;
      if (outVec() !== 29'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", i, outVec(), 29'd0);
      end
    end
    Resetn = 1'b0;
    bus.Run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      compared++;
      if (outVec() !== 29'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_release cycle %0d: got %h expected %h", i, outVec(), 29'd0);
      end
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_mv();
    logic [28:0] expSeq [5];
    bit runSeq [5] = '{1, 0, 0, 0, 0};
    bus.Instrucao = {OP_MV, 3'd2, 3'd5};
    bus.MemRdy = 1'b1;
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h20) | fRin(8'h04) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 5; i++) begin
      bus.Run = runSeq[i];
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL mv cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_sub_wait();
    logic [28:0] expSeq [10];
    bit rdySeq [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    bus.Instrucao = {OP_SUB, 3'd1, 3'd3};
    expSeq = '{29'd0, E_FETCH, O_BUSY, O_BUSY, O_BUSY, E_FWRDY,
               fRout(8'h02) | O_AIN | O_BUSY,
               fRout(8'h08) | O_GIN | fUla(2'b01) | O_BUSY,
               O_GOUT | fRin(8'h02) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 10; i++) begin
      bus.Run = (i == 0);
      bus.MemRdy = rdySeq[i];
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL sub_wait cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_and();
    logic [28:0] expSeq [7];
    bus.Instrucao = {OP_AND, 3'd3, 3'd4};
    bus.MemRdy = 1'b1;
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h08) | O_AIN | O_BUSY,
               fRout(8'h10) | O_GIN | fUla(2'b10) | O_BUSY,
               O_GOUT | fRin(8'h08) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 7; i++) begin
      bus.Run = (i == 0);
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL and cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_mvnz();
    logic [28:0] expSeq [5];
    bus.Instrucao = {OP_MVNZ, 3'd4, 3'd0};
    bus.MemRdy = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.GRout = (p == 0) ? 16'h0000 : 16'h0001;
      expSeq = '{29'd0, E_FETCH, E_FWRDY,
                 (p == 0) ? (O_DONE | O_BUSY)
                          : (fRout(8'h01) | fRin(8'h10) | O_DONE | O_BUSY),
                 29'd0};
      for (int i = 0; i < 5; i++) begin
        bus.Run = (i == 0);
        @(negedge Clock);
        compared++;
        if (outVec() !== expSeq[i]) begin
          mismatched++;
          $display("[TB] FAIL mvnz G=%0d cycle %0d: got %h expected %h", p, i, outVec(), expSeq[i]);
        end
        @(posedge Clock); #1;
      end
    end
    bus.GRout = 16'h0000;
  endtask

  task automatic test_ld_wait();
    logic [28:0] expSeq [7];
    bit rdySeq [7] = '{1, 1, 1, 1, 0, 1, 1};
    bus.Instrucao = {OP_LD, 3'd5, 3'd1};
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h02) | O_ADDRIN | O_BUSY, O_BUSY,
               O_DINOUT | fRin(8'h20) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 7; i++) begin
      bus.Run = (i == 0);
      bus.MemRdy = rdySeq[i];
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL ld_wait cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_mvi_pc();
    logic [28:0] expSeq [6];
    bus.Instrucao = {OP_MVI, 3'd7, 3'd0};
    bus.MemRdy = 1'b1;
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h80) | O_ADDRIN | O_BUSY,
               O_DINOUT | fRin(8'h80) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 6; i++) begin
      bus.Run = (i == 0);
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL mvi_pc cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_st_wait();
    logic [28:0] expSeq [9];
    bit rdySeq [9] = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
    bus.Instrucao = {OP_ST, 3'd6, 3'd2};
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h04) | O_ADDRIN | O_BUSY,
               fRout(8'h40) | O_DOUTIN | O_BUSY,
               O_WD | O_BUSY, O_WD | O_BUSY, O_WD | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 9; i++) begin
      bus.Run = (i == 0);
      bus.MemRdy = rdySeq[i];
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL st_wait cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_st_reset();
    logic [28:0] expSeq [7];
    bit rdySeq [7] = '{0, 0, 1, 0, 0, 1, 1};
    bit rstSeq [7] = '{0, 0, 0, 0, 1, 0, 0};
    bus.Instrucao = {OP_ST, 3'd6, 3'd2};
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h04) | O_ADDRIN | O_BUSY,
               fRout(8'h40) | O_DOUTIN | O_BUSY, 29'd0, 29'd0};
    for (int i = 0; i < 7; i++) begin
      bus.Run = (i == 0);
      bus.MemRdy = rdySeq[i];
      Resetn = rstSeq[i];
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL st_reset cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
    Resetn = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [28:0] expSeq [12];
    bit rdySeq [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    expSeq = '{29'd0, E_FETCH, E_FWRDY,
               fRout(8'h80) | O_ADDRIN | O_BUSY, O_BUSY,
               O_DINOUT | fRin(8'h01) | O_INCR | O_DONE | O_BUSY,
               E_FETCH, E_FWRDY,
               fRout(8'h01) | O_AIN | O_BUSY,
               fRout(8'h01) | O_GIN | fUla(2'b00) | O_BUSY,
               O_GOUT | fRin(8'h01) | O_DONE | O_BUSY, 29'd0};
    for (int i = 0; i < 12; i++) begin
      bus.Run = (i < 8);
      bus.MemRdy = rdySeq[i];
      bus.Instrucao = (i < 8) ? {OP_MVI, 3'd0, 3'd0} : {OP_ADD, 3'd0, 3'd0};
      @(negedge Clock);
      compared++;
      if (outVec() !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", i, outVec(), expSeq[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    Resetn = 1'b1;
    bus.Run = 1'b0;
    bus.MemRdy = 1'b0;
    bus.GRout = 16'h0000;
    bus.Instrucao = '0;
    test_reset();
    test_mv();
    test_sub_wait();
    test_and();
    test_mvnz();
    test_ld_wait();
    test_mvi_pc();
    test_st_wait();
    test_st_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
